// File: rtl/int_div_if.sv
// int_div_if: request/result bundle for the unsigned divider
interface int_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] yshang;
  logic [WIDTH-1:0] yyushu;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  modport master (output start, a, b, input yshang, yyushu, busy, done, div_by_zero);
  modport slave  (input start, a, b, output yshang, yyushu, busy, done, div_by_zero);
endinterface

// File: rtl/int_div.sv
// int_div: multi-cycle radix-2 restoring unsigned divider, one quotient bit per cycle
module int_div #(parameter int WIDTH = 32) (
  input logic     clk,
  input logic     rst,
  int_div_if.slave d
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t           st;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd, rem, dvs;
  logic [WIDTH:0]   pr, sub;
  logic             ge;
  always_comb begin
    pr  = {rem, dvd[WIDTH-1]};
    ge  = pr >= {1'b0, dvs};
    sub = pr - {1'b0, dvs};
  end
  // dvd shifts the dividend out at the top while quotient bits fill in from the bottom
  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      rem           <= '0;
      dvs           <= '0;
      d.yshang      <= '0;
      d.yyushu      <= '0;
      d.busy        <= 1'b0;
      d.done        <= 1'b0;
      d.div_by_zero <= 1'b0;
    end else begin
      case (st)
        IDLE: if (d.start) begin
          dvd    <= d.a;
          dvs    <= d.b;
          rem    <= '0;
          cnt    <= '0;
          d.busy <= 1'b1;
          st     <= BUSY;
        end
        BUSY: if (cnt == CW'(WIDTH)) begin
          d.yshang      <= dvd;
          d.yyushu      <= rem;
          d.div_by_zero <= dvs == '0;
          d.done        <= 1'b1;
          st            <= DONE;
        end else begin
          rem    <= ge ? sub[WIDTH-1:0] : pr[WIDTH-1:0];
          dvd    <= {dvd[WIDTH-2:0], ge};
          cnt    <= cnt + 1'b1;
          d.busy <= cnt != CW'(WIDTH - 1);
        end
        DONE: begin
          d.done <= 1'b0;
          st     <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_int_div.sv
// tb_int_div: directed corners plus random operands against an arithmetic reference
module tb_int_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int_div_if #(.WIDTH(32)) f();
  int_div #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .d(f));
  int total = 0;
  int bad = 0;
  logic [31:0] pq = '0;
  logic [31:0] pr = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(f.busy), 0);
    chk({tag, "_done"}, 64'(f.done), 0);
    chk({tag, "_q"}, 64'(f.yshang), 0);
    chk({tag, "_r"}, 64'(f.yyushu), 0);
    chk({tag, "_dbz"}, 64'(f.div_by_zero), 0);
  endtask
  // call at a negedge; returns #1 after the edge following the done cycle
  task automatic do_div(input logic [31:0] x, input logic [31:0] y, input bit inj);
    logic [31:0] eq, er;
    int n, nb;
    eq = (y == 0) ? 32'hFFFF_FFFF : x / y;
    er = (y == 0) ? x : x % y;
    f.start = 1'b1;
    f.a = x;
    f.b = y;
    @(posedge clk);
    #1;
    f.start = 1'b0;
    f.a = $urandom;
    f.b = $urandom;
    n = 0;
    nb = f.busy ? 1 : 0;
    while (!f.done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      nb += f.busy ? 1 : 0;
      if (n == 10) begin
        chk("hold_q", 64'(f.yshang), 64'(pq));
        chk("hold_r", 64'(f.yyushu), 64'(pr));
        if (inj) begin
          f.start = 1'b1;
          f.a = 32'd1;
          f.b = 32'd1;
        end
      end
      if (n == 11) f.start = 1'b0;
    end
    chk("latency", 64'(n), 33);
    chk("busy_cycles", 64'(nb), 32);
    chk("q", 64'(f.yshang), 64'(eq));
    chk("r", 64'(f.yyushu), 64'(er));
    chk("dbz", 64'(f.div_by_zero), 64'(y == 0));
    @(posedge clk);
    #1;
    chk("done_pulse", 64'(f.done), 0);
    chk("idle_busy", 64'(f.busy), 0);
    chk("q_held", 64'(f.yshang), 64'(eq));
    pq = eq;
    pr = er;
  endtask
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'd1;
      3: return $urandom >> $urandom_range(0, 31);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    f.start = 1'b0;
    f.a = '0;
    f.b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd100, 32'd7, 0);
    @(negedge clk);
    do_div(32'hFFFF_FFFF, 32'd1, 0);
    @(negedge clk);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 0);
    @(negedge clk);
    do_div(32'd5, 32'd0, 0);
    @(negedge clk);
    do_div(32'd0, 32'd13, 0);
    @(negedge clk);
    do_div(32'd9999, 32'd999, 1);
    @(negedge clk);
    f.start = 1'b1;
    f.a = 32'd12345;
    f.b = 32'd6;
    @(posedge clk);
    #1;
    f.start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero("mid_reset");
    pq = '0;
    pr = '0;
    @(negedge clk);
    rst = 1'b0;
    do_div(32'd99, 32'd9, 0);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      do_div(pick(), pick(), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
